// File: rtl/hi_lo_unit.sv
// hi_lo_unit: HI/LO special registers with mult write, mthi/mtlo and two-cycle madd/msub accumulate
module hi_lo_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        OpValid,
  input  logic [2:0]  HiLoOp,
  input  logic [31:0] ProductHi,
  input  logic [31:0] ProductLo,
  input  logic [31:0] MoveData,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic        Busy,
  output logic        Done
);
  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI} state_t;
  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] p_q, p_d;
  logic        sub_q, sub_d, c_q, c_d, done_q, done_d;
  logic [32:0] lo_sum;
  logic [31:0] hi_acc;
  // carry-chained halves of the accumulate; the carry/borrow links LO into HI
  always_comb begin
    lo_sum = sub_q ? {lo_q < p_q[31:0], lo_q - p_q[31:0]} : {1'b0, lo_q} + {1'b0, p_q[31:0]};
    hi_acc = sub_q ? hi_q - p_q[63:32] - {31'd0, c_q} : hi_q + p_q[63:32] + {31'd0, c_q};
  end
  // next-state and register updates; ops are only accepted in IDLE
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    p_d     = p_q;
    sub_d   = sub_q;
    c_d     = c_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (OpValid) begin
        unique case (HiLoOp)
          3'b001: begin
            hi_d   = ProductHi;
            lo_d   = ProductLo;
            done_d = 1'b1;
          end
          3'b010, 3'b011: begin
            p_d     = {ProductHi, ProductLo};
            sub_d   = HiLoOp[0];
            state_d = ACC_LO;
          end
          3'b100: begin
            hi_d   = MoveData;
            done_d = 1'b1;
          end
          3'b101: begin
            lo_d   = MoveData;
            done_d = 1'b1;
          end
          default: ;
        endcase
      end
      ACC_LO: begin
        {c_d, lo_d} = lo_sum;
        state_d     = ACC_HI;
      end
      ACC_HI: begin
        hi_d    = hi_acc;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers, cleared asynchronously so a reset aborts any accumulate
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      p_q     <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      p_q     <= p_d;
      sub_q   <= sub_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end
  assign HiOut = hi_q;
  assign LoOut = lo_q;
  assign Busy  = (state_q != IDLE);
  assign Done  = done_q;
endmodule

// File: tb/tb_hi_lo_unit.sv
// tb_hi_lo_unit: directed self-checking bench for hi_lo_unit
module tb_hi_lo_unit;
  logic        Clk = 1'b0, Reset = 1'b0, OpValid = 1'b0;
  logic [2:0]  HiLoOp = '0;
  logic [31:0] ProductHi = '0, ProductLo = '0, MoveData = '0;
  logic [31:0] HiOut, LoOut;
  logic        Busy, Done;
  int          n_chk = 0, n_pass = 0;

  hi_lo_unit dut (
    .Clk(Clk), .Reset(Reset), .OpValid(OpValid), .HiLoOp(HiLoOp),
    .ProductHi(ProductHi), .ProductLo(ProductLo), .MoveData(MoveData),
    .HiOut(HiOut), .LoOut(LoOut), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic state(input string tag, input logic [31:0] hi, input logic [31:0] lo, input logic busy, input logic done);
    chk({tag, ".hi"}, HiOut, hi);
    chk({tag, ".lo"}, LoOut, lo);
    chk({tag, ".busy"}, {31'd0, Busy}, {31'd0, busy});
    chk({tag, ".done"}, {31'd0, Done}, {31'd0, done});
  endtask

  task automatic op(input logic [2:0] o, input logic [31:0] ph, input logic [31:0] pl, input logic [31:0] md);
    OpValid = 1'b1; HiLoOp = o; ProductHi = ph; ProductLo = pl; MoveData = md;
  endtask

  task automatic set_hilo(input logic [31:0] hi, input logic [31:0] lo);
    op(3'b100, '0, '0, hi); tick();
    op(3'b101, '0, '0, lo); tick();
    OpValid = 1'b0; tick();
  endtask

  initial begin
    #1 state("rst", 0, 0, 0, 0);
    @(negedge Clk); Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); state("idle", 0, 0, 0, 0); end

    op(3'b001, 32'h1, 32'hFFFF_FFFE, '0); tick(); OpValid = 1'b0;
    state("mult", 32'h1, 32'hFFFF_FFFE, 0, 1);
    tick(); state("mult_after", 32'h1, 32'hFFFF_FFFE, 0, 0);

    op(3'b110, 32'h5, 32'h6, 32'h7); tick(); OpValid = 1'b0;
    state("reserved", 32'h1, 32'hFFFF_FFFE, 0, 0);

    set_hilo(32'h0, 32'hFFFF_FFFF);
    state("pre_madd", 32'h0, 32'hFFFF_FFFF, 0, 0);
    op(3'b010, 32'h0, 32'h1, '0); tick();
    OpValid = 1'b0; ProductHi = 32'hDEAD_BEEF; ProductLo = 32'hDEAD_BEEF;
    state("madd_n1", 32'h0, 32'hFFFF_FFFF, 1, 0);
    tick(); state("madd_n2", 32'h0, 32'h0, 1, 0);
    tick(); state("madd_n3", 32'h1, 32'h0, 0, 1);
    tick(); state("madd_n4", 32'h1, 32'h0, 0, 0);

    set_hilo(32'h1, 32'h0);
    op(3'b011, 32'h0, 32'h1, '0); tick(); OpValid = 1'b0;
    state("msub_n1", 32'h1, 32'h0, 1, 0);
    tick(); state("msub_n2", 32'h1, 32'hFFFF_FFFF, 1, 0);
    tick(); state("msub_n3", 32'h0, 32'hFFFF_FFFF, 0, 1);

    op(3'b010, 32'h0, 32'h5, '0); tick();
    op(3'b100, '0, '0, 32'h1234_5678);
    state("hold_n1", 32'h0, 32'hFFFF_FFFF, 1, 0);
    tick(); state("hold_n2", 32'h0, 32'h4, 1, 0);
    tick(); state("hold_n3", 32'h1, 32'h4, 0, 1);
    tick(); OpValid = 1'b0;
    state("mthi_late", 32'h1234_5678, 32'h4, 0, 1);
    tick(); state("mthi_after", 32'h1234_5678, 32'h4, 0, 0);

    op(3'b010, 32'h0, 32'h1, '0); tick(); OpValid = 1'b0;
    tick(); state("abort_lo", 32'h1234_5678, 32'h5, 1, 0);
    #2 Reset = 1'b0;
    #1 state("abort_rst", 0, 0, 0, 0);
    @(negedge Clk); Reset = 1'b1;
    tick(); state("abort_post1", 0, 0, 0, 0);
    tick(); state("abort_post2", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
